// File: rtl/spi_frame_rx.sv
// SPI mode-0 note-frame receiver: synchronizes sck/sdi/cs_n into clk, assembles
// FRAME_BITS-bit frames and flags bad-length transfers. Optional macro SPI_FRAME_CHANGE_ONLY_EN.
module spi_frame_rx #(
    parameter int FRAME_BITS  = 48,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  sck,
    input  logic                  sdi,
    input  logic                  cs_n,
    output logic [FRAME_BITS-1:0] frame_data,
    output logic                  frame_valid,
    output logic                  frame_err,
    output logic                  busy
);
    localparam int CNT_W = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(FRAME_BITS);

    typedef enum logic [1:0] {IDLE, RECV, OVF} state_t;

    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic                   sck_hist_q, sck_hist_d;
    logic                   cs_hist_q, cs_hist_d;
    logic                   sck_rise_q, sck_rise_d;
    logic                   cs_rise_q, cs_rise_d;
    logic                   cs_fall_q, cs_fall_d;
    logic                   sdi_smp_q, sdi_smp_d;
    logic [SYNC_STAGES:0]   settle_q, settle_d;
    logic                   armed_q, armed_d;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [FRAME_BITS-1:0]  shreg_q, shreg_d;
    logic [FRAME_BITS-1:0]  frame_data_q, frame_data_d;
    logic                   frame_valid_q, frame_valid_d;
    logic                   frame_err_q, frame_err_d;

    logic sck_s, cs_s, sdi_s;
    assign sck_s = sck_sync_q[SYNC_STAGES-1];
    assign cs_s  = cs_sync_q[SYNC_STAGES-1];
    assign sdi_s = sdi_sync_q[SYNC_STAGES-1];

    // Synchronizers, edge detection and the post-reset arming logic. Events are
    // registered so sck, sdi and cs_n all reach the FSM with identical delay.
    always_comb begin
        sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], sck};
        sdi_sync_d = {sdi_sync_q[SYNC_STAGES-2:0], sdi};
        cs_sync_d  = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
        sck_hist_d = sck_s;
        cs_hist_d  = cs_s;
        sck_rise_d = sck_s & ~sck_hist_q;
        cs_rise_d  = cs_s & ~cs_hist_q;
        cs_fall_d  = ~cs_s & cs_hist_q;
        sdi_smp_d  = sdi_s;
        settle_d   = {settle_q[SYNC_STAGES-1:0], 1'b1};
        // A cs_n fall only counts once the real pin has been seen high after reset,
        // so a transfer cut by reset is ignored until a fresh select.
        armed_d    = armed_q | (settle_q[SYNC_STAGES] & cs_s & cs_hist_q);
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sck_sync_q    <= '0;
            sdi_sync_q    <= '0;
            cs_sync_q     <= '1;
            sck_hist_q    <= 1'b0;
            cs_hist_q     <= 1'b1;
            sck_rise_q    <= 1'b0;
            cs_rise_q     <= 1'b0;
            cs_fall_q     <= 1'b0;
            sdi_smp_q     <= 1'b0;
            settle_q      <= '0;
            armed_q       <= 1'b0;
            state_q       <= IDLE;
            cnt_q         <= '0;
            shreg_q       <= '0;
            frame_data_q  <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            sck_sync_q    <= sck_sync_d;
            sdi_sync_q    <= sdi_sync_d;
            cs_sync_q     <= cs_sync_d;
            sck_hist_q    <= sck_hist_d;
            cs_hist_q     <= cs_hist_d;
            sck_rise_q    <= sck_rise_d;
            cs_rise_q     <= cs_rise_d;
            cs_fall_q     <= cs_fall_d;
            sdi_smp_q     <= sdi_smp_d;
            settle_q      <= settle_d;
            armed_q       <= armed_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shreg_q       <= shreg_d;
            frame_data_q  <= frame_data_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shreg_d       = shreg_q;
        frame_data_d  = frame_data_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cs_fall_q && armed_q) begin
                    cnt_d   = '0;
                    shreg_d = '0;
                    state_d = RECV;
                end
            end
            RECV: begin
                // The sck rise is applied first so a coincident cs_n rise sees the final bit.
                if (sck_rise_q) begin
                    if (cnt_q == FULL) begin
                        state_d = OVF;
                    end else begin
                        shreg_d = {shreg_q[FRAME_BITS-2:0], sdi_smp_q};
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
                if (cs_rise_q) begin
                    state_d = IDLE;
                    if (sck_rise_q && cnt_q == FULL) begin
                        frame_err_d = 1'b1;
                    end else if (cnt_d == FULL) begin
`ifdef SPI_FRAME_CHANGE_ONLY_EN
                        if (shreg_d != frame_data_q) begin
                            frame_data_d  = shreg_d;
                            frame_valid_d = 1'b1;
                        end
`else
                        frame_data_d  = shreg_d;
                        frame_valid_d = 1'b1;
`endif
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            OVF: begin
                if (cs_rise_q) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
    end

    assign frame_data  = frame_data_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_spi_frame_rx.sv
// Directed bench for spi_frame_rx: drives SPI transfers at sck = clk/8 and checks
// pulses against a scoreboard queue of expected frame outcomes.
module tb_spi_frame_rx;
    localparam int FB = 48;
    localparam int SS = 2;
    localparam int LAT = SS + 2;

    logic          clk = 1'b0;
    logic          nreset = 1'b0;
    logic          sck = 1'b0;
    logic          sdi = 1'b0;
    logic          cs_n = 1'b1;
    logic [FB-1:0] frame_data;
    logic          frame_valid;
    logic          frame_err;
    logic          busy;

    typedef struct {
        logic          is_err;
        logic [FB-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;
    logic [FB-1:0] exp_frame = '0;

    spi_frame_rx #(.FRAME_BITS(FB), .SYNC_STAGES(SS)) dut (
        .clk(clk), .nreset(nreset), .sck(sck), .sdi(sdi), .cs_n(cs_n),
        .frame_data(frame_data), .frame_valid(frame_valid),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        assert (got === expv) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, expv);
        end
    endtask

    task automatic push_exp(input logic is_err, input logic [FB-1:0] d);
        exp_t e;
        e.is_err = is_err;
        e.data   = d;
        exp_q.push_back(e);
    endtask

    task automatic send_bits(input logic [63:0] d, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            sdi = d[i];
            #20 sck = 1'b1;
            #40 sck = 1'b0;
            #20;
        end
    endtask

    task automatic start_frame();
        cs_n = 1'b0;
        #60;
    endtask

    // Raises cs_n just after a clk edge and reports how many edges later a pulse appeared.
    task automatic end_frame(input logic with_sck, output int lat);
        #20;
        @(posedge clk);
        #1;
        cs_n = 1'b1;
        if (with_sck) sck = 1'b1;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (lat == 0 && (frame_valid || frame_err)) lat = k;
        end
        sck = 1'b0;
        #100;
    endtask

    // Scoreboard side: every pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (nreset && (frame_valid || frame_err)) begin
            exp_t e;
            chk("valid_err_exclusive", {63'd0, frame_valid & frame_err}, 64'd0);
            chk("pulse_expected", {63'd0, exp_q.size() != 0}, 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("pulse_kind_err", {63'd0, frame_err}, {63'd0, e.is_err});
                if (!e.is_err) chk("pulse_data", {16'd0, frame_data}, {16'd0, e.data});
            end
        end
    end

    initial begin
        int lat;
        logic [FB-1:0] f1, f2, f3;
        f1 = 48'h0A1B2C3D4E5F;
        f2 = 48'h112233445566;
        f3 = 48'hA5C30F961E79;

        #23;
        chk("rst_frame_data", {16'd0, frame_data}, 64'd0);
        chk("rst_valid", {63'd0, frame_valid}, 64'd0);
        chk("rst_err", {63'd0, frame_err}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1 nreset = 1'b1;
        repeat (10) @(posedge clk);

        // Full good frame.
        push_exp(1'b0, f1);
        start_frame();
        send_bits({16'd0, f1}, FB);
        chk("busy_in_frame", {63'd0, busy}, 64'd1);
        end_frame(1'b0, lat);
        exp_frame = f1;
        chk("f1_latency", lat, LAT);
        chk("f1_data", {16'd0, frame_data}, {16'd0, exp_frame});

        // Short frame.
        push_exp(1'b1, '0);
        start_frame();
        send_bits(64'h00C0FFEE1234, 40);
        end_frame(1'b0, lat);
        chk("short_latency", lat, LAT);
        chk("short_data_kept", {16'd0, frame_data}, {16'd0, exp_frame});

        // Overlong frame.
        push_exp(1'b1, '0);
        start_frame();
        send_bits(64'h0002_5555_AAAA_3C3C, 50);
        chk("ovf_busy", {63'd0, busy}, 64'd1);
        end_frame(1'b0, lat);
        chk("ovf_latency", lat, LAT);
        chk("ovf_data_kept", {16'd0, frame_data}, {16'd0, exp_frame});
        chk("ovf_idle", {63'd0, busy}, 64'd0);

        // Repeated identical frame.
`ifdef SPI_FRAME_CHANGE_ONLY_EN
        start_frame();
        send_bits({16'd0, f1}, FB);
        end_frame(1'b0, lat);
        chk("dup_latency", lat, 0);
`else
        push_exp(1'b0, f1);
        start_frame();
        send_bits({16'd0, f1}, FB);
        end_frame(1'b0, lat);
        chk("dup_latency", lat, LAT);
`endif
        chk("dup_data", {16'd0, frame_data}, {16'd0, exp_frame});

        // Last sck rise coincident with the cs_n rise: the bit must be counted.
        push_exp(1'b0, f3);
        start_frame();
        send_bits({17'd0, f3[FB-1:1]}, FB - 1);
        sdi = f3[0];
        end_frame(1'b1, lat);
        exp_frame = f3;
        chk("coinc_latency", lat, LAT);
        chk("coinc_data", {16'd0, frame_data}, {16'd0, exp_frame});

        // Reset in the middle of a transfer.
        start_frame();
        send_bits({16'd0, f2}, 20);
        @(posedge clk);
        #1 nreset = 1'b0;
        #1;
        exp_frame = '0;
        chk("midrst_data", {16'd0, frame_data}, 64'd0);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        #30;
        @(posedge clk);
        #1 nreset = 1'b1;
        send_bits({16'd0, f2}, 28);
        chk("aborted_busy", {63'd0, busy}, 64'd0);
        end_frame(1'b0, lat);
        chk("aborted_latency", lat, 0);
        chk("aborted_data", {16'd0, frame_data}, 64'd0);

        push_exp(1'b0, f2);
        start_frame();
        send_bits({16'd0, f2}, FB);
        end_frame(1'b0, lat);
        exp_frame = f2;
        chk("f2_latency", lat, LAT);
        chk("f2_data", {16'd0, frame_data}, {16'd0, exp_frame});

        // sck activity without a chip select.
        sdi = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #40 sck = 1'b1;
            #40 sck = 1'b0;
            if (i == 8) chk("nocs_busy_mid", {63'd0, busy}, 64'd0);
        end
        repeat (10) @(posedge clk);
        #1;
        chk("nocs_busy", {63'd0, busy}, 64'd0);
        chk("nocs_data", {16'd0, frame_data}, {16'd0, exp_frame});

        chk("scoreboard_empty", exp_q.size(), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_frame_rx.md
SPI_FRAME_RX -- requirements
Module: spi_frame_rx

Interface
REQ-001 SHALL have parameter FRAME_BITS, default 48, giving the number of SPI bits per note frame (six 8-bit signal bytes, MSB first).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth on sck, sdi and cs_n (minimum 2).
REQ-003 Ports, in order:
- clk  input  1  system clock (int_osc, 24 MHz); the only clock.
- nreset  input  1  asynchronous reset, active-low.
- sck  input  1  SPI clock from the MCU; asynchronous to clk; mode 0 (CPOL=0, CPHA=0).
- sdi  input  1  SPI data from the MCU, MSB first.
- cs_n  input  1  SPI chip select, active-low, frames one transfer.
- frame_data  output  FRAME_BITS  last accepted frame; bit [FRAME_BITS-1] is the first bit received.
- frame_valid  output  1  one-clk pulse when frame_data is updated.
- frame_err  output  1  one-clk pulse when a transfer ends with a wrong bit count.
- busy  output  1  high while a transfer is in progress (state RECV or OVF).

Function
REQ-004 SHALL pass sck, sdi and cs_n through SYNC_STAGES-flop synchronizers clocked by clk, plus one further history flop per signal for edge detection.
REQ-005 SHALL detect an sck rise when the synced sck is 1 and its history is 0; sdi SHALL be sampled from the synced sdi in the same cycle, so both take equal delay.
REQ-006 SHALL guarantee correct capture only for sck high and low phases of at least 3 clk periods each; faster sck is outside the contract.
REQ-007 SHALL implement states IDLE, RECV and OVF.
REQ-008 In IDLE: on a synced cs_n fall, clear the bit counter and shift register and go to RECV; sck rises SHALL be ignored.
REQ-009 In RECV: each sck rise SHALL shift the sampled sdi into the LSB of the shift register and increment the counter; a rise when the counter equals FRAME_BITS SHALL go to OVF without shifting.
REQ-010 In OVF: sck rises SHALL be ignored.
REQ-011 On a synced cs_n rise in RECV with counter == FRAME_BITS, SHALL load frame_data from the shift register and pulse frame_valid for exactly one cycle, registered (the cycle after detection), then go to IDLE.
REQ-012 On a synced cs_n rise in RECV with counter != FRAME_BITS, or in OVF, SHALL pulse frame_err for one cycle, leave frame_data unchanged, and go to IDLE.
REQ-013 An sck rise and a cs_n rise detected in the same cycle SHALL process the sck rise first; the bit is counted before the end-of-frame decision.
REQ-014 A cs_n fall while in RECV or OVF cannot occur without an intervening rise; it SHALL be ignored.
REQ-015 frame_valid and frame_err SHALL never be high in the same cycle.
REQ-016 The counter SHALL be $clog2(FRAME_BITS+1) bits wide and SHALL never wrap; it saturates via the OVF state.
REQ-017 Latency SHALL be SYNC_STAGES+2 clk cycles from the cs_n rising pin edge to the frame_valid or frame_err pulse.
REQ-018 frame_data SHALL stay stable between frame_valid pulses so the downstream tune stage can use it directly.

Reset
REQ-019 On nreset low, asynchronously: state=IDLE, counter=0, shift register=0, frame_data=0, frame_valid=0, frame_err=0, busy=0, all synchronizer and history flops=1 for cs_n and 0 for sck/sdi.
REQ-020 Reset asserted mid-transfer SHALL abort it with no pulse; after release, the rest of that transfer (cs_n already low) SHALL be ignored until a fresh cs_n fall.

Configuration
REQ-021 Macro SPI_FRAME_CHANGE_ONLY_EN:
- When defined: a correct-length frame equal to the current frame_data SHALL produce no frame_valid pulse and leave frame_data unchanged (no note restart on repeated data).
- When undefined: every correct-length frame SHALL pulse frame_valid.
- frame_err behaviour SHALL be identical either way.

Verification
REQ-022 After reset, send 48-bit frame 0x0A1B2C3D4E5F with sck = clk/8 → one frame_valid pulse 4 cycles after the cs_n rise; frame_data=0x0A1B2C3D4E5F; frame_err=0 throughout.
REQ-023 Send 40 bits then raise cs_n → one frame_err pulse; frame_data keeps its previous value; frame_valid stays 0.
REQ-024 Send 50 bits → state OVF after bit 49; frame_err pulse at the cs_n rise; frame_data unchanged.
REQ-025 Send the same frame 0x0A1B2C3D4E5F twice → with SPI_FRAME_CHANGE_ONLY_EN, exactly one frame_valid pulse; without it, two.
REQ-026 Assert nreset after bit 20, release it with cs_n still low, finish the transfer, then send a full frame 0x112233445566 → no pulses for the aborted transfer; then frame_valid with frame_data=0x112233445566.
REQ-027 Toggle sck 16 times with cs_n high → busy=0, no pulses, frame_data unchanged.
